// File: rtl/note_freq_interp.sv
// MIDI note + fine tune - pitch fall -> 11-bit Game Boy wave-channel frequency register value,
// via a per-note register ROM and linear interpolation between adjacent notes.
`timescale 1ns/1ps
module note_freq_interp #(
  parameter int unsigned FALL_SHIFT = 0,
  parameter int unsigned CLAMP_LO   = 0,
  parameter int unsigned CLAMP_HI   = 2047
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        start,
  input  logic [6:0]  note,
  input  logic [7:0]  fine,
  input  logic [12:0] fall_amount,
  output logic [10:0] freq,
  output logic        freq_valid,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CALC, RD0, RD1, MUL, DONE} state_t;

  // lut[n] = clamp(round(2048 - 65536 / f(n)), 0, 2047), f(n) = 440 * 2^((n-69)/12)
  localparam logic [10:0] LUT [128] = '{
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
    44, 157, 263, 363, 457, 547, 631, 711, 786, 856, 923, 986,
    1046, 1102, 1155, 1205, 1253, 1297, 1339, 1379, 1417, 1452, 1486, 1517,
    1547, 1575, 1602, 1627, 1650, 1673, 1694, 1714, 1732, 1750, 1767, 1783,
    1798, 1812, 1825, 1837, 1849, 1860, 1871, 1881, 1890, 1899, 1907, 1915,
    1923, 1930, 1936, 1943, 1949, 1954, 1959, 1964, 1969, 1974, 1978, 1982,
    1985, 1989, 1992, 1995, 1998, 2001, 2004, 2006, 2009, 2011, 2013, 2015,
    2017, 2018, 2020, 2022, 2023, 2025, 2026, 2027, 2028, 2029, 2030, 2031,
    2032, 2033, 2034, 2035, 2036, 2036, 2037, 2038, 2038, 2039, 2039, 2040,
    2040, 2041, 2041, 2041, 2042, 2042, 2042, 2043
  };

  localparam logic signed [12:0] LO_S  = 13'(CLAMP_LO);
  localparam logic signed [12:0] HI_S  = 13'(CLAMP_HI);
  localparam logic signed [16:0] P_MAX = 17'sd32512;

  state_t        state, state_nx;
  logic [6:0]    note_r;
  logic [7:0]    fine_r;
  logic [12:0]   fall_r;
  logic          pending;
  logic [6:0]    idx_r;
  logic [7:0]    frac_r;
  logic [10:0]   x0_r, x1_r;
  logic [10:0]   rom_q;
  logic [6:0]    rom_addr;

  logic [12:0]        fall_sh;
  logic signed [16:0] p_raw;
  logic [14:0]        p_clamp;
  logic [10:0]        diff;
  logic [18:0]        prod;
  logic [10:0]        y;
  logic signed [12:0] y_s;
  logic [10:0]        y_clamped;

  always_comb begin
    fall_sh = fall_r >> FALL_SHIFT;
    p_raw   = $signed({2'b00, note_r, 8'h00}) + $signed({{9{fine_r[7]}}, fine_r})
            - $signed({4'b0000, fall_sh});
    if (p_raw[16])           p_clamp = '0;
    else if (p_raw > P_MAX)  p_clamp = 15'd32512;
    else                     p_clamp = p_raw[14:0];
  end

  // Address is the live index in CALC, then the saturated next index for the x1 fetch.
  always_comb begin
    if (state == CALC)        rom_addr = p_clamp[14:8];
    else if (idx_r == 7'd127) rom_addr = idx_r;
    else                      rom_addr = idx_r + 7'd1;
  end

  // Read is gated by en so a stalled RD0/RD1 keeps the word it is waiting to latch.
  always_ff @(posedge clk) begin
    if (en) rom_q <= LUT[rom_addr];
  end

  always_comb begin
    diff = x1_r - x0_r;
    prod = 19'(diff) * 19'(frac_r);
    y    = x0_r + 11'(prod >> 8);
    y_s  = $signed({2'b00, y});
    if (y_s < LO_S)      y_clamped = LO_S[10:0];
    else if (y_s > HI_S) y_clamped = HI_S[10:0];
    else                 y_clamped = y;
  end

  always_comb begin
    state_nx = state;
    if (en) begin
      unique case (state)
        IDLE:    if (start) state_nx = CALC;
        CALC:    state_nx = RD0;
        RD0:     state_nx = RD1;
        RD1:     state_nx = MUL;
        MUL:     state_nx = DONE;
        DONE:    state_nx = (start || pending) ? CALC : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pending <= 1'b0;
      freq    <= '0;
      note_r  <= '0;
      fine_r  <= '0;
      fall_r  <= '0;
      idx_r   <= '0;
      frac_r  <= '0;
      x0_r    <= '0;
      x1_r    <= '0;
    end else if (en) begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          note_r <= note;
          fine_r <= fine;
          fall_r <= fall_amount;
        end
        CALC: begin
          idx_r  <= p_clamp[14:8];
          frac_r <= p_clamp[7:0];
          if (start) pending <= 1'b1;
        end
        RD0: begin
          x0_r <= rom_q;
          if (start) pending <= 1'b1;
        end
        RD1: begin
          x1_r <= rom_q;
          if (start) pending <= 1'b1;
        end
        MUL: begin
          freq <= y_clamped;
          if (start) pending <= 1'b1;
        end
        DONE: begin
          pending <= 1'b0;
          if (start || pending) begin
            note_r <= note;
            fine_r <= fine;
            fall_r <= fall_amount;
          end
        end
        default: ;
      endcase
    end
  end

  assign freq_valid = en && (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_note_freq_interp.sv
// Scoreboard bench for note_freq_interp: expected freq values come from a real-arithmetic
// model of the note table and interpolation; a negedge monitor pops them on each freq_valid.
`timescale 1ns/1ps
module tb_note_freq_interp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  note = '0;
  logic [7:0]  fine = '0;
  logic [12:0] fall_amount = '0;
  logic [10:0] freq;
  logic        freq_valid;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int cyc     = 0;
  int start_cyc = 0;
  int last_valid_cyc = 0;
  int exp_q[$];

  note_freq_interp #(.FALL_SHIFT(0), .CLAMP_LO(0), .CLAMP_HI(2047)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start), .note(note), .fine(fine),
    .fall_amount(fall_amount), .freq(freq), .freq_valid(freq_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lut_ref(input int n);
    real f, v;
    int r;
    f = 440.0 * $pow(2.0, (n - 69) / 12.0);
    v = 2048.0 - 65536.0 / f;
    if (v < 0.0) return 0;
    r = $rtoi(v + 0.5);
    return (r > 2047) ? 2047 : r;
  endfunction

  // Pitch in 1/256 semitone, clamped to the table span, then linear blend of neighbours.
  function automatic int model(input int n, input int fi, input int fa);
    int p, idx, frac, x0, x1, y;
    p = n * 256 + fi - fa;
    if (p < 0) p = 0;
    if (p > 127 * 256) p = 127 * 256;
    idx  = p / 256;
    frac = p % 256;
    x0 = lut_ref(idx);
    x1 = (idx < 127) ? lut_ref(idx + 1) : x0;
    y  = x0 + ((x1 - x0) * frac) / 256;
    if (y < 0) y = 0;
    if (y > 2047) y = 2047;
    return y;
  endfunction

  always @(negedge clk) begin
    if (!reset && freq_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
      else check("freq", int'(freq), exp_q.pop_front());
    end
  end

  task automatic issue(input int n, input int fi, input int fa, input int e);
    @(posedge clk); #1;
    note = n[6:0]; fine = fi[7:0]; fall_amount = fa[12:0];
    en = 1'b1; start = 1'b1;
    start_cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int budget);
    int k = 0;
    while (n_valid < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    check("pulse_count", n_valid, target);
  endtask

  task automatic wait_idle();
    int k = 0;
    en = 1'b1;
    while (busy && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle", int'(busy), 0);
  endtask

  task automatic directed(input string name, input int n, input int fi, input int fa,
                          input int e);
    int tgt;
    wait_idle();
    tgt = n_valid + 1;
    issue(n, fi, fa, e);
    check({name, "_busy"}, int'(busy), 1);
    wait_pulses(tgt, 20);
    check({name, "_lat"}, last_valid_cyc - start_cyc, 5);
  endtask

  initial begin
    int s0, tgt, n, fi, fa;
    repeat (3) @(negedge clk);
    check("rst_freq", int'(freq), 0);
    check("rst_valid", int'(freq_valid), 0);
    check("rst_busy", int'(busy), 0);
    @(posedge clk); #1 reset = 1'b0;

    directed("a4", 69, 0, 0, 1899);
    directed("fall12", 69, 0, 3072, 1750);
    directed("halfstep", 70, -128, 0, 1903);
    directed("clamp_lo", 0, 0, 7680, 0);
    directed("clamp_hi", 127, 127, 0, 2043);
    directed("mdl_mid", 45, 77, 900, model(45, 77, 900));

    // Starts in RD0 and RD1 collapse into one follow-up conversion with note 81.
    wait_idle();
    tgt = n_valid + 2;
    issue(69, 0, 0, 1899);
    s0 = start_cyc;
    @(posedge clk); #1;
    note = 7'd81; fine = '0; fall_amount = '0; start = 1'b1;
    exp_q.push_back(1974);
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_pulses(tgt, 30);
    wait_idle();
    repeat (4) @(posedge clk);
    #1 check("pending_pulses", n_valid, tgt);
    check("pending_lat", last_valid_cyc - s0, 10);

    // Start presented in the DONE cycle gives a back-to-back conversion.
    wait_idle();
    tgt = n_valid + 2;
    issue(69, 0, 0, 1899);
    s0 = start_cyc;
    repeat (4) @(posedge clk);
    #1;
    note = 7'd72; start = 1'b1;
    exp_q.push_back(1923);
    @(posedge clk); #1;
    start = 1'b0;
    wait_pulses(tgt, 30);
    check("done_b2b_lat", last_valid_cyc - s0, 10);

    // Reset during RD1 aborts the conversion immediately.
    wait_idle();
    issue(60, 0, 0, 1798);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("abort_freq", int'(freq), 0);
    check("abort_valid", int'(freq_valid), 0);
    check("abort_busy", int'(busy), 0);
    @(posedge clk); #1 reset = 1'b0;
    directed("after_abort", 69, 0, 0, 1899);

    // Two cycles of en low mid-run push the pulse out by two cycles.
    wait_idle();
    tgt = n_valid + 1;
    issue(69, 0, 0, 1899);
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk); #1 en = 1'b1;
    wait_pulses(tgt, 20);
    check("en_lat", last_valid_cyc - start_cyc, 7);

    // Random conversions with random en stalls and input noise while busy.
    for (int t = 0; t < 40; t++) begin
      int k;
      wait_idle();
      n  = $urandom_range(0, 127);
      fi = $urandom_range(0, 255) - 128;
      fa = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 600) : $urandom_range(0, 8191);
      tgt = n_valid + 1;
      issue(n, fi, fa, model(n, fi, fa));
      k = 0;
      while (n_valid < tgt && k < 80) begin
        en = ($urandom_range(0, 3) != 0);
        note = 7'($urandom);
        fine = 8'($urandom);
        fall_amount = 13'($urandom);
        @(posedge clk); #1;
        k++;
      end
      en = 1'b1;
      check("rand_pulse", n_valid, tgt);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
